// File: rtl/fetch_prefetch.sv
// Purpose: in-order instruction prefetcher feeding the front-end queue, with credit and redirect handling.
// Latency: request one cycle after enable or redirect; response at cycle N is written to the queue at N+1.
// Backpressure: requests stall when outstanding plus dropped reaches MAX_OUT or reserved entries reach Q_DEPTH.
module fetch_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                Q_DEPTH  = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     pf_en,
    input  logic                     pf_redirect,
    input  logic [ADDR_W-1:0]        pf_redirect_pc,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     imem_err,
    output logic                     pf_q_wen,
    output logic [ADDR_W+DATA_W:0]   pf_q_wdata,
    output logic                     pf_q_flush,
    input  logic                     pf_q_pop
);

    localparam int QCW = $clog2(Q_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUT + 1);
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [QCW-1:0] QD_LIM  = QCW'(Q_DEPTH);
    localparam logic [OCW:0]   OUT_LIM = (OCW + 1)'(MAX_OUT);
    localparam logic [PW-1:0]  P_LAST  = PW'(MAX_OUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [OCW-1:0]      r_out;
    logic [OCW-1:0]      r_drop;
    logic [QCW-1:0]      r_res;
    logic [OCW-1:0]      w_out_nxt;
    logic [OCW-1:0]      w_drop_nxt;
    logic [QCW-1:0]      w_res_nxt;
    logic [ADDR_W-1:0]   r_pc_fifo [MAX_OUT];
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp;
    logic                r_wen;
    logic [ADDR_W+DATA_W:0] r_wdata;

    logic                w_req;
    logic                w_gnt;
    logic                w_rsp_drop;
    logic                w_rsp_acc;
    logic [OCW:0]        w_bus_busy;
    logic [ADDR_W-1:0]   w_redir_pc;

    // Dropped responses still occupy the bus, so they count against MAX_OUT.
    assign w_bus_busy = {1'b0, r_out} + {1'b0, r_drop};
    assign w_req      = (r_state == ST_FETCH) & ~pf_redirect
                      & (w_bus_busy < OUT_LIM) & (r_res < QD_LIM);
    assign w_gnt      = w_req & imem_gnt;
    assign w_rsp_drop = imem_rvalid & (r_drop != '0);
    assign w_rsp_acc  = imem_rvalid & (r_drop == '0) & ~pf_redirect;
    assign w_redir_pc = pf_redirect_pc & ~ADDR_W'(3);

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign pf_q_wen   = r_wen;
    assign pf_q_wdata = r_wdata;
    assign pf_q_flush = pf_redirect;

    // Next-state: redirect overrides everything; an accepted error response parks the fetcher.
    always_comb begin
        w_state_nxt = r_state;
        if (pf_redirect) begin
            w_state_nxt = pf_en ? ST_FETCH : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (pf_en) w_state_nxt = ST_FETCH;
                ST_FETCH: begin
                    if (w_rsp_acc && imem_err) w_state_nxt = ST_FAULT;
                    else if (!pf_en)           w_state_nxt = ST_IDLE;
                end
                ST_FAULT: w_state_nxt = ST_FAULT;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counter arithmetic: on redirect every in-flight request becomes a drop and the queue is emptied.
    always_comb begin
        w_out_nxt  = r_out + OCW'(w_gnt) - OCW'(w_rsp_acc);
        w_drop_nxt = r_drop - OCW'(w_rsp_drop);
        w_res_nxt  = r_res + QCW'(w_gnt) - QCW'(w_rsp_drop) - QCW'(pf_q_pop);
        if (pf_redirect) begin
            w_drop_nxt = r_drop + r_out - OCW'(imem_rvalid);
            w_out_nxt  = '0;
            w_res_nxt  = QCW'(w_drop_nxt);
        end
    end

    // State, pc, counters and PC FIFO pointers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
            r_res   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_drop  <= w_drop_nxt;
            r_res   <= w_res_nxt;
            if (pf_redirect) begin
                r_pc <= w_redir_pc;
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_gnt) begin
                    r_pc <= r_pc + ADDR_W'(4);
                    r_wp <= (r_wp == P_LAST) ? '0 : r_wp + PW'(1);
                end
                if (w_rsp_acc) begin
                    r_rp <= (r_rp == P_LAST) ? '0 : r_rp + PW'(1);
                end
            end
        end
    end

    // PC FIFO storage; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge CLK) begin
        if (w_gnt) begin
            r_pc_fifo[r_wp] <= r_pc;
        end
    end

    // Registered queue write; data holds between writes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_rsp_acc;
            if (w_rsp_acc) begin
                r_wdata <= {imem_err, r_pc_fifo[r_rp], imem_rdata};
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;

    logic        CLK;
    logic        RSTN;
    logic        pf_en;
    logic        pf_redirect;
    logic [31:0] pf_redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        pf_q_wen;
    logic [64:0] pf_q_wdata;
    logic        pf_q_flush;
    logic        pf_q_pop;

    int n_cmp;
    int n_bad;

    fetch_prefetch #(
        .ADDR_W(32), .DATA_W(32), .Q_DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .pf_en(pf_en), .pf_redirect(pf_redirect), .pf_redirect_pc(pf_redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .pf_q_wen(pf_q_wen), .pf_q_wdata(pf_q_wdata), .pf_q_flush(pf_q_flush),
        .pf_q_pop(pf_q_pop)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        rd;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdat;
        logic        err;
        logic        pop;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ewen;
        logic [64:0] ewd;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] dat(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    function automatic logic [64:0] ent(input logic e, input logic [31:0] pc);
        return {e, pc, dat(pc)};
    endfunction

    task automatic add(input logic en, input logic rd, input logic [31:0] rpc,
                       input logic gnt, input logic rv, input logic [31:0] rpc_of_rsp,
                       input logic err, input logic pop, input logic ereq,
                       input logic [31:0] eaddr, input logic ewen, input logic [64:0] ewd);
        vec_t v;
        v.en = en; v.rd = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv;
        v.rdat = rv ? dat(rpc_of_rsp) : 32'h0;
        v.err = err; v.pop = pop;
        v.ereq = ereq; v.eaddr = eaddr; v.ewen = ewen; v.ewd = ewd;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rd, input logic [31:0] rpc,
                         input logic gnt, input logic rv, input logic [31:0] rdat,
                         input logic err, input logic pop);
        pf_en = en; pf_redirect = rd; pf_redirect_pc = rpc; imem_gnt = gnt;
        imem_rvalid = rv; imem_rdata = rdat; imem_err = err; pf_q_pop = pop;
    endtask

    initial begin
        logic [64:0] z;
        z = 65'h0;
        n_cmp = 0;
        n_bad = 0;

        //   en rd rpc          gnt rv rsp_pc err pop | req addr         wen wdata
        add(1, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 32'h0,       0, z);
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   1, 32'h0,       0, z);
        add(1, 0, 32'h0,        1, 1, 32'h0,    0, 0,   1, 32'h4,       0, z);
        add(1, 0, 32'h0,        1, 1, 32'h4,    0, 1,   1, 32'h8,       1, ent(0, 32'h0));
        add(0, 0, 32'h0,        0, 1, 32'h8,    0, 1,   1, 32'hC,       1, ent(0, 32'h4));
        add(0, 0, 32'h0,        0, 0, 32'h0,    0, 1,   0, 32'hC,       1, ent(0, 32'h8));
        add(0, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 32'hC,       0, ent(0, 32'h8));
        add(1, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 32'hC,       0, ent(0, 32'h8));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   1, 32'hC,       0, ent(0, 32'h8));
        add(1, 0, 32'h0,        1, 1, 32'hC,    0, 0,   1, 32'h10,      0, ent(0, 32'h8));
        add(1, 0, 32'h0,        1, 1, 32'h10,   0, 0,   1, 32'h14,      1, ent(0, 32'hC));
        add(1, 0, 32'h0,        1, 1, 32'h14,   0, 0,   1, 32'h18,      1, ent(0, 32'h10));
        add(1, 0, 32'h0,        1, 1, 32'h18,   0, 0,   0, 32'h1C,      1, ent(0, 32'h14));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   0, 32'h1C,      1, ent(0, 32'h18));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 1,   0, 32'h1C,      0, ent(0, 32'h18));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   1, 32'h1C,      0, ent(0, 32'h18));
        add(1, 0, 32'h0,        1, 1, 32'h1C,   0, 0,   0, 32'h20,      0, ent(0, 32'h18));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   0, 32'h20,      1, ent(0, 32'h1C));
        add(1, 0, 32'h0,        0, 0, 32'h0,    0, 1,   0, 32'h20,      0, ent(0, 32'h1C));
        add(1, 0, 32'h0,        0, 0, 32'h0,    0, 1,   1, 32'h20,      0, ent(0, 32'h1C));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 1,   1, 32'h20,      0, ent(0, 32'h1C));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 1,   1, 32'h24,      0, ent(0, 32'h1C));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   0, 32'h28,      0, ent(0, 32'h1C));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   0, 32'h28,      0, ent(0, 32'h1C));
        add(1, 0, 32'h0,        1, 1, 32'h20,   0, 0,   0, 32'h28,      0, ent(0, 32'h1C));
        add(1, 0, 32'h0,        1, 1, 32'h24,   0, 0,   1, 32'h28,      1, ent(0, 32'h20));
        add(1, 0, 32'h0,        0, 0, 32'h0,    0, 0,   1, 32'h2C,      1, ent(0, 32'h24));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 1,   1, 32'h2C,      0, ent(0, 32'h24));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 1,   0, 32'h30,      0, ent(0, 32'h24));
        add(1, 1, 32'h1003,     1, 0, 32'h0,    0, 0,   0, 32'h30,      0, ent(0, 32'h24));
        add(1, 0, 32'h0,        1, 1, 32'h28,   0, 0,   0, 32'h1000,    0, ent(0, 32'h24));
        add(1, 0, 32'h0,        1, 1, 32'h2C,   0, 0,   1, 32'h1000,    0, ent(0, 32'h24));
        add(1, 0, 32'h0,        0, 1, 32'h1000, 0, 0,   1, 32'h1004,    0, ent(0, 32'h24));
        add(1, 0, 32'h0,        0, 0, 32'h0,    0, 0,   1, 32'h1004,    1, ent(0, 32'h1000));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   1, 32'h1004,    0, ent(0, 32'h1000));
        add(1, 0, 32'h0,        0, 1, 32'h1004, 1, 0,   1, 32'h1008,    0, ent(0, 32'h1000));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   0, 32'h1008,    1, ent(1, 32'h1004));
        add(1, 1, 32'h40,       1, 0, 32'h0,    0, 0,   0, 32'h1008,    0, ent(1, 32'h1004));
        add(1, 0, 32'h0,        1, 0, 32'h0,    0, 0,   1, 32'h40,      0, ent(1, 32'h1004));
        add(0, 0, 32'h0,        0, 1, 32'h40,   0, 0,   1, 32'h44,      0, ent(1, 32'h1004));
        add(0, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 32'h44,      1, ent(0, 32'h40));

        // Reset values, including the combinational flush path.
        RSTN = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        #2;
        chk("rst_req",   65'(imem_req),  65'(1'b0));
        chk("rst_addr",  65'(imem_addr), 65'(32'h0));
        chk("rst_wen",   65'(pf_q_wen),  65'(1'b0));
        chk("rst_wdata", pf_q_wdata,     z);
        chk("rst_flush0", 65'(pf_q_flush), 65'(1'b0));
        pf_redirect = 1'b1;
        #1;
        chk("rst_flush1", 65'(pf_q_flush), 65'(1'b1));
        pf_redirect = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].rd, vt[i].rpc, vt[i].gnt, vt[i].rv, vt[i].rdat, vt[i].err, vt[i].pop);
            #1;
            chk($sformatf("v%0d_req", i),   65'(imem_req),   65'(vt[i].ereq));
            chk($sformatf("v%0d_addr", i),  65'(imem_addr),  65'(vt[i].eaddr));
            chk($sformatf("v%0d_wen", i),   65'(pf_q_wen),   65'(vt[i].ewen));
            chk($sformatf("v%0d_wdata", i), pf_q_wdata,      vt[i].ewd);
            chk($sformatf("v%0d_flush", i), 65'(pf_q_flush), 65'(vt[i].rd));
            @(negedge CLK);
        end

        // Address wrap, and a response landing in a redirect cycle is never written.
        drive(1, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 0);
        #1;
        chk("s1_flush", 65'(pf_q_flush), 65'(1'b1));
        chk("s1_req",   65'(imem_req),   65'(1'b0));
        @(negedge CLK);
        drive(1, 0, 32'h0, 1, 0, 32'h0, 0, 0);
        #1;
        chk("s2_req",  65'(imem_req),  65'(1'b1));
        chk("s2_addr", 65'(imem_addr), 65'(32'hFFFF_FFFC));
        @(negedge CLK);
        drive(1, 1, 32'h200, 0, 1, dat(32'hFFFF_FFFC), 0, 0);
        #1;
        chk("s3_addr_wrap", 65'(imem_addr), 65'(32'h0));
        chk("s3_req",       65'(imem_req),  65'(1'b0));
        chk("s3_flush",     65'(pf_q_flush), 65'(1'b1));
        @(negedge CLK);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        #1;
        chk("s4_wen_suppr", 65'(pf_q_wen),  65'(1'b0));
        chk("s4_wdata",     pf_q_wdata,     ent(0, 32'h40));
        chk("s4_req",       65'(imem_req),  65'(1'b1));
        chk("s4_addr",      65'(imem_addr), 65'(32'h200));
        @(negedge CLK);
        drive(1, 0, 32'h0, 1, 0, 32'h0, 0, 0);
        #1;
        chk("s5_req", 65'(imem_req), 65'(1'b1));
        @(posedge CLK);
        #1;
        chk("s5_addr_adv", 65'(imem_addr), 65'(32'h204));

        // Reset mid-operation returns outputs to reset values immediately.
        RSTN = 1'b0;
        #1;
        chk("mrst_req",   65'(imem_req),  65'(1'b0));
        chk("mrst_addr",  65'(imem_addr), 65'(32'h0));
        chk("mrst_wen",   65'(pf_q_wen),  65'(1'b0));
        chk("mrst_wdata", pf_q_wdata,     z);
        @(negedge CLK);
        RSTN = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
